panda_if_stage: RTL and testbench

PANDA_IF_STAGE -- requirements
Module: panda_if_stage

---
 rtl/panda_pkg.sv | 5 +
 rtl/panda_if_stage.sv | 55 +++++
 tb/tb_panda_if_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/panda_pkg.sv
// panda_pkg: shared width and instruction constants for the panda core
package panda_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/panda_if_stage.sv
// panda_if_stage: instruction fetch stage with PC, IF/ID register and stall hold buffer
module panda_if_stage
  import panda_pkg::*;
#(
  parameter logic [XLEN-1:0] BootAddr = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_if_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_id_o,
  output logic [XLEN-1:0] pc_id_o,
  output logic            valid_id_o
);
  localparam logic [XLEN-1:0] BootPc = {BootAddr[XLEN-1:2], 2'b00};
  logic [XLEN-1:0] pc_q, pc_d, pc_id_q, pc_id_d, hold_instr_q, hold_instr_d;
  logic            valid_id_q, valid_id_d, hold_valid_q, hold_valid_d;
  // next state: redirect beats stall, stall freezes everything but the hold buffer
  always_comb begin
    pc_d         = branch_taken_i ? {branch_target_i[XLEN-1:2], 2'b00} :
                   stall_if_i     ? pc_q : pc_q + XLEN'(4);
    pc_id_d      = (branch_taken_i || stall_if_i) ? pc_id_q : pc_q;
    valid_id_d   = branch_taken_i ? 1'b0 : stall_if_i ? valid_id_q : 1'b1;
    hold_valid_d = !branch_taken_i && stall_if_i;
    hold_instr_d = (!branch_taken_i && stall_if_i && !hold_valid_q) ? imem_rdata_i : hold_instr_q;
  end
  // state registers, cleared to the boot image on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q         <= BootPc;
      pc_id_q      <= BootPc;
      valid_id_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP;
    end else begin
      pc_q         <= pc_d;
      pc_id_q      <= pc_id_d;
      valid_id_q   <= valid_id_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
    end
  end
  // memory stalls must not lose the word fetched before the stall began
  always_comb begin
    imem_req_o  = rst_ni && !stall_if_i;
    imem_addr_o = pc_q;
    pc_id_o     = pc_id_q;
    valid_id_o  = valid_id_q;
    instr_id_o  = !valid_id_q ? NOP : hold_valid_q ? hold_instr_q : imem_rdata_i;
  end
endmodule

// File: tb/tb_panda_if_stage.sv
// tb_panda_if_stage: scoreboard bench for panda_if_stage against a transaction-level fetch model
module tb_panda_if_stage;
  import panda_pkg::*;
  localparam logic [31:0] BOOT = 32'h0000_0100;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  logic        clk = 1'b0, rst_ni = 1'b0, stall = 1'b0, br = 1'b0;
  logic [31:0] tgt = '0, rdata = '0;
  logic        imem_req, valid_id;
  logic [31:0] imem_addr, instr_id, pc_id;
  int          errors = 0, checks = 0;
  exp_t        sb[$];
  logic [31:0] m_pc = BOOT, m_pcid = BOOT, rt;
  logic        m_valid = 1'b0;

  panda_if_stage #(.BootAddr(BOOT)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .stall_if_i(stall), .branch_taken_i(br),
    .branch_target_i(tgt), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rdata_i(rdata), .instr_id_o(instr_id), .pc_id_o(pc_id), .valid_id_o(valid_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // synchronous instruction memory; returns junk on cycles with no request
  always @(posedge clk) rdata <= imem_req ? mem(imem_addr) : $urandom();

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // monitor: compare presented outputs with the model, retire ID entries as they leave
  always @(negedge clk) begin
    if (!rst_ni) begin
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, BOOT);
      chk("rst_instr", instr_id, NOP);
      chk("rst_pcid", pc_id, BOOT);
      chk("rst_valid", 32'(valid_id), 32'd0);
    end else begin
      chk("addr", imem_addr, m_pc);
      chk("req", 32'(imem_req), 32'(!stall));
      chk("valid", 32'(valid_id), 32'(m_valid));
      chk("pc_id", pc_id, m_pcid);
      if (!m_valid) chk("bubble", instr_id, NOP);
      else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got valid instr %h expected none", instr_id);
      end else begin
        chk("sb_pc", pc_id, sb[0].pc);
        chk("sb_instr", instr_id, sb[0].ins);
        if (!stall || br) void'(sb.pop_front());
      end
    end
  end

  task automatic drive(input logic s, input logic b, input logic [31:0] t);
    stall = s;
    br    = b;
    tgt   = t;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_ni) begin
      if (br) begin
        m_pc    = {tgt[31:2], 2'b00};
        m_valid = 1'b0;
      end else if (!stall) begin
        sb.push_back(exp_t'{m_pc, mem(m_pc)});
        m_pcid  = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(1'b0, 1'b0, 32'd0);
    sb.delete();
    m_pc    = BOOT;
    m_pcid  = BOOT;
    m_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    do_reset();
    drive(0, 0, 0); @(negedge clk); chk("boot_addr", imem_addr, 32'h100); tick();
    drive(0, 0, 0); @(negedge clk); chk("c2_addr", imem_addr, 32'h104);
    chk("c2_pcid", pc_id, 32'h100); chk("c2_valid", 32'(valid_id), 32'd1); tick();
    repeat (3) begin
      drive(1, 0, 0); @(negedge clk);
      chk("stall_addr", imem_addr, 32'h108); chk("stall_pcid", pc_id, 32'h104);
      chk("stall_instr", instr_id, mem(32'h104)); chk("stall_req", 32'(imem_req), 32'd0);
      tick();
    end
    drive(0, 0, 0); @(negedge clk); chk("release_instr", instr_id, mem(32'h104)); tick();
    drive(0, 1, 32'h2002); @(negedge clk); chk("resume_pcid", pc_id, 32'h108); tick();
    drive(0, 0, 0); @(negedge clk);
    chk("br_addr", imem_addr, 32'h2000); chk("br_valid", 32'(valid_id), 32'd0);
    chk("br_nop", instr_id, NOP); chk("br_pcid", pc_id, 32'h108); tick();
    drive(1, 1, 32'h400); @(negedge clk);
    chk("tgt_pcid", pc_id, 32'h2000); chk("tgt_instr", instr_id, mem(32'h2000)); tick();
    drive(1, 0, 0); @(negedge clk); chk("prio_addr", imem_addr, 32'h400); tick();
    drive(0, 0, 0); @(negedge clk); chk("stall_nop", 32'(valid_id), 32'd0); tick();
    drive(0, 1, 32'hFFFF_FFFE); tick();
    drive(0, 0, 0); @(negedge clk); chk("top_addr", imem_addr, 32'hFFFF_FFFC); tick();
    drive(0, 0, 0); @(negedge clk); chk("wrap_addr", imem_addr, 32'h0); tick();
    drive(1, 0, 0); tick();
    @(negedge clk); #1 rst_ni = 1'b0; #1;
    chk("async_req", 32'(imem_req), 32'd0); chk("async_addr", imem_addr, BOOT);
    chk("async_instr", instr_id, NOP); chk("async_valid", 32'(valid_id), 32'd0);
    chk("async_pcid", pc_id, BOOT);
    do_reset();
    drive(0, 0, 0); @(negedge clk); chk("restart_addr", imem_addr, BOOT); tick();
    for (int i = 0; i < 600; i++) begin
      rt = $urandom();
      if ($urandom_range(0, 3) == 0) rt = 32'hFFFF_FFF0 | (rt & 32'hF);
      else rt = rt & 32'h0000_3FFF;
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 12, rt);
      tick();
    end
    drive(1, 0, 0);
    @(negedge clk);
    chk("sb_left", 32'(sb.size()), 32'(m_valid));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
